regfile_seq: RTL and testbench

//  Micro-sequencer for the general register file: accepts one register-register op at a time
//  (rd <- f(rs1, rs2)) over a valid/ready handshake. Drives the file's lSel/rSel/oSel and

---
 rtl/regfile_seq.sv | 155 +++++++++++++++
 tb/tb_regfile_seq.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_seq.sv
// Micro-sequencer for one register-register op: read rs1/rs2, run the external ALU, write rd back.
// Latency: accept edge E, done pulse at E+5 (E+4 when wen=0) with a one-cycle ALU; op_ready again a cycle later.
// Backpressure: op_ready is high only in IDLE; one op in flight, and op_* are ignored while busy.
//
// Ports:
//   clk, res            clock and synchronous active-high reset
//   op_valid/op_ready   op handshake; op_rd/op_rs1/op_rs2/op_wen describe the op
//   lSel/rSel/oSel      regfile selects, zero whenever the matching strobe is low
//   LOUT/ROUT/OIN       regfile read/write strobes; o is the write-back data
//   l, r                regfile read data, valid the cycle after LOUT/ROUT
//   alu_a/alu_b         latched operands; alu_start pulses once; alu_done/alu_y return the result
//   done/err            completion pulse; err=1 means the ALU timed out and nothing was written
module regfile_seq #(
    parameter int WIDTH       = 16,
    parameter int REG_WIDTH   = 4,
    parameter int ALU_TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 res,
    input  logic                 op_valid,
    output logic                 op_ready,
    input  logic [REG_WIDTH-1:0] op_rd,
    input  logic [REG_WIDTH-1:0] op_rs1,
    input  logic [REG_WIDTH-1:0] op_rs2,
    input  logic                 op_wen,
    output logic [REG_WIDTH-1:0] lSel,
    output logic [REG_WIDTH-1:0] rSel,
    output logic [REG_WIDTH-1:0] oSel,
    output logic                 LOUT,
    output logic                 ROUT,
    output logic                 OIN,
    output logic [WIDTH-1:0]     o,
    input  logic [WIDTH-1:0]     l,
    input  logic [WIDTH-1:0]     r,
    output logic [WIDTH-1:0]     alu_a,
    output logic [WIDTH-1:0]     alu_b,
    output logic                 alu_start,
    input  logic                 alu_done,
    input  logic [WIDTH-1:0]     alu_y,
    output logic                 done,
    output logic                 err
);

    localparam int CW = $clog2(ALU_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_LATCH,
        S_EXEC,
        S_WB,
        S_DONE
    } state_t;

    state_t               state;
    logic [REG_WIDTH-1:0] rd_q;
    logic                 wen_q;
    logic [CW-1:0]        cnt;

    // Every output is a register that is loaded on the transition into the
    // state that owns it, so nothing combinational reaches a port from an input.
    always_ff @(posedge clk) begin
        if (res) begin
            state     <= S_IDLE;
            op_ready  <= 1'b1;
            rd_q      <= '0;
            wen_q     <= 1'b0;
            cnt       <= '0;
            lSel      <= '0;
            rSel      <= '0;
            oSel      <= '0;
            LOUT      <= 1'b0;
            ROUT      <= 1'b0;
            OIN       <= 1'b0;
            o         <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_start <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (op_valid) begin
                        // lSel/rSel hold rs1/rs2 for the READ cycle.
                        rd_q     <= op_rd;
                        wen_q    <= op_wen;
                        lSel     <= op_rs1;
                        rSel     <= op_rs2;
                        LOUT     <= 1'b1;
                        ROUT     <= 1'b1;
                        op_ready <= 1'b0;
                        state    <= S_READ;
                    end
                end
                S_READ: begin
                    LOUT  <= 1'b0;
                    ROUT  <= 1'b0;
                    lSel  <= '0;
                    rSel  <= '0;
                    state <= S_LATCH;
                end
                S_LATCH: begin
                    // The file registers its outputs, so l/r are valid only now.
                    alu_a     <= l;
                    alu_b     <= r;
                    alu_start <= 1'b1;
                    cnt       <= CW'(1);
                    state     <= S_EXEC;
                end
                S_EXEC: begin
                    alu_start <= 1'b0;
                    // alu_done is checked first so a result on the last allowed
                    // cycle still counts as success.
                    if (alu_done) begin
                        if (wen_q) begin
                            OIN   <= 1'b1;
                            oSel  <= rd_q;
                            o     <= alu_y;
                            state <= S_WB;
                        end else begin
                            done  <= 1'b1;
                            err   <= 1'b0;
                            state <= S_DONE;
                        end
                    end else if (cnt == CW'(ALU_TIMEOUT)) begin
                        done  <= 1'b1;
                        err   <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_WB: begin
                    OIN   <= 1'b0;
                    oSel  <= '0;
                    o     <= '0;
                    done  <= 1'b1;
                    err   <= 1'b0;
                    state <= S_DONE;
                end
                S_DONE: begin
                    done     <= 1'b0;
                    err      <= 1'b0;
                    op_ready <= 1'b1;
                    state    <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_seq.sv
// Bench for regfile_seq: a behavioural regfile and a configurable-latency ALU surround the DUT;
// every op is checked cycle by cycle against the schedule the op should follow and the write-back it should produce.
// Inputs are driven at negedge or #1 after posedge; outputs are sampled at negedge.
module tb_regfile_seq;

    localparam int W  = 16;
    localparam int RW = 4;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          res;
    logic          op_valid;
    logic          op_ready;
    logic [RW-1:0] op_rd, op_rs1, op_rs2;
    logic          op_wen;
    logic [RW-1:0] lSel, rSel, oSel;
    logic          LOUT, ROUT, OIN;
    logic [W-1:0]  o;
    logic [W-1:0]  l, r;
    logic [W-1:0]  alu_a, alu_b;
    logic          alu_start;
    logic          alu_done;
    logic [W-1:0]  alu_y;
    logic          done, err;

    int nchk  = 0;
    int nfail = 0;

    regfile_seq #(.WIDTH(W), .REG_WIDTH(RW), .ALU_TIMEOUT(TO)) dut (
        .clk(clk), .res(res),
        .op_valid(op_valid), .op_ready(op_ready),
        .op_rd(op_rd), .op_rs1(op_rs1), .op_rs2(op_rs2), .op_wen(op_wen),
        .lSel(lSel), .rSel(rSel), .oSel(oSel),
        .LOUT(LOUT), .ROUT(ROUT), .OIN(OIN),
        .o(o), .l(l), .r(r),
        .alu_a(alu_a), .alu_b(alu_b), .alu_start(alu_start),
        .alu_done(alu_done), .alu_y(alu_y),
        .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // Register file model: registered reads, write on OIN, plus a preload port.
    logic [W-1:0]  rf [16];
    logic          pl_en;
    logic [RW-1:0] pl_idx;
    logic [W-1:0]  pl_dat;

    always @(posedge clk) begin
        if (pl_en) rf[pl_idx] <= pl_dat;
        if (LOUT)  l <= rf[lSel];
        if (ROUT)  r <= rf[rSel];
        if (OIN)   rf[oSel] <= o;
    end

    // ALU model: alu_done rises alu_lat cycles after alu_start (0 = same cycle).
    int           alu_lat;
    logic         alu_fen;
    logic [W-1:0] alu_fval;
    int           ecnt;
    logic         armed;
    int           alu_k;

    always @(posedge clk) begin
        if (res) begin
            armed <= 1'b0;
            ecnt  <= 0;
        end else begin
            ecnt <= alu_start ? 1 : ecnt + 1;
            if (alu_done || done) armed <= 1'b0;
            else if (alu_start)   armed <= 1'b1;
        end
    end

    assign alu_k    = alu_start ? 0 : ecnt;
    assign alu_done = (alu_start || armed) && (alu_k == alu_lat);
    assign alu_y    = alu_fen ? alu_fval : alu_a + alu_b;

    // Reference register contents, updated from the op semantics only.
    logic [W-1:0] refrf [16];

    task automatic chk(input string tag, input int t, input logic [63:0] obs, input logic [63:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s t=%0d observed %h expected %h", tag, t, obs, exp);
        end
    endtask

    task automatic preload(input logic [RW-1:0] idx, input logic [W-1:0] val);
        pl_en  = 1'b1;
        pl_idx = idx;
        pl_dat = val;
        @(posedge clk);
        #1 pl_en = 1'b0;
        refrf[idx] = val;
        @(negedge clk);
    endtask

    // Called at a negedge with the DUT idle. Expected schedule relative to accept edge E:
    // READ E+1, LATCH E+2, EXEC from E+3 for min(lat+1, TO) cycles, WB if writing, DONE, then idle.
    task automatic run_op(input logic [RW-1:0] rd, input logic [RW-1:0] rs1, input logic [RW-1:0] rs2,
                          input logic wen, input int lat, input logic fen, input logic [W-1:0] fval,
                          input logic hold, input logic [RW-1:0] nrd, input logic [RW-1:0] nrs1,
                          input logic [RW-1:0] nrs2, input logic nwen);
        logic [W-1:0] ea, eb, y;
        logic         tmo, wb, is_wb;
        int           xl, td;
        logic [34:0]  ev, ov;

        chk("ready_before_op", 0, {63'd0, op_ready}, 64'd1);
        ea  = refrf[rs1];
        eb  = refrf[rs2];
        y   = fen ? fval : ea + eb;
        tmo = (lat >= TO);
        xl  = tmo ? TO : lat + 1;
        wb  = wen && !tmo;
        td  = 3 + xl + (wb ? 1 : 0);

        alu_lat  = lat;
        alu_fen  = fen;
        alu_fval = fval;
        op_valid = 1'b1;
        op_rd    = rd;
        op_rs1   = rs1;
        op_rs2   = rs2;
        op_wen   = wen;
        @(posedge clk);
        #1;
        if (hold) begin
            // Keep requesting with the next op's fields while this one runs.
            op_rd  = nrd;
            op_rs1 = nrs1;
            op_rs2 = nrs2;
            op_wen = nwen;
        end else begin
            op_valid = 1'b0;
        end

        for (int t = 1; t <= td + 1; t++) begin
            @(negedge clk);
            is_wb = wb && (t == td - 1);
            ev = {t == td + 1, t == 1, t == 1,
                  (t == 1) ? rs1 : 4'd0, (t == 1) ? rs2 : 4'd0,
                  is_wb, is_wb ? rd : 4'd0, is_wb ? y : 16'd0,
                  t == 3, t == td, tmo && (t == td)};
            ov = {op_ready, LOUT, ROUT, lSel, rSel, OIN, oSel, o, alu_start, done, err};
            chk("schedule", t, {29'd0, ov}, {29'd0, ev});
            if (t >= 3 && t < 3 + xl)
                chk("operands", t, {32'd0, alu_a, alu_b}, {32'd0, ea, eb});
        end
        if (wb) refrf[rd] = y;
        chk("regfile_rd", td, {48'd0, rf[rd]}, {48'd0, refrf[rd]});
    endtask

    typedef struct {
        logic [RW-1:0] rd, rs1, rs2;
        logic          wen;
        int            lat;
        logic          hold;
    } rop_t;

    rop_t rops [21];

    initial begin
        res      = 1'b1;
        op_valid = 1'b0;
        op_rd    = '0;
        op_rs1   = '0;
        op_rs2   = '0;
        op_wen   = 1'b0;
        pl_en    = 1'b0;
        pl_idx   = '0;
        pl_dat   = '0;
        alu_lat  = 1000;
        alu_fen  = 1'b0;
        alu_fval = '0;

        // Reset state, while in reset and one cycle after release.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", 0,
            {29'd0, op_ready, LOUT, ROUT, lSel, rSel, OIN, oSel, o, alu_start, done, err},
            {29'd0, 35'h4_0000_0000});
        chk("reset_operands", 0, {32'd0, alu_a, alu_b}, 64'd0);
        res = 1'b0;
        @(negedge clk);
        chk("post_reset_idle", 1,
            {29'd0, op_ready, LOUT, ROUT, lSel, rSel, OIN, oSel, o, alu_start, done, err},
            {29'd0, 35'h4_0000_0000});

        for (int i = 0; i < 16; i++) preload(4'(i), 16'($urandom));
        preload(4'd1, 16'd5);
        preload(4'd2, 16'd3);

        // Basic add: 5 + 3 -> R3.
        run_op(4'd3, 4'd1, 4'd2, 1'b1, 0, 1'b0, 16'h0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0);
        chk("basic_R3", 0, {48'd0, rf[3]}, 64'd8);

        // Slow ALU with a fixed result.
        run_op(4'd5, 4'd1, 4'd2, 1'b1, 4, 1'b1, 16'h00AA, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0);
        chk("slow_R5", 0, {48'd0, rf[5]}, 64'h00AA);

        // Compare-only: R4 must be untouched.
        preload(4'd4, 16'h1234);
        run_op(4'd4, 4'd1, 4'd2, 1'b0, 0, 1'b0, 16'h0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0);
        chk("wen0_R4", 0, {48'd0, rf[4]}, 64'h1234);

        // Timeout, then result on the last allowed cycle.
        preload(4'd9, 16'h0F0F);
        run_op(4'd9, 4'd1, 4'd2, 1'b1, 1000, 1'b0, 16'h0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0);
        chk("timeout_R9", 0, {48'd0, rf[9]}, 64'h0F0F);
        run_op(4'd9, 4'd1, 4'd2, 1'b1, TO - 1, 1'b0, 16'h0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0);
        chk("last_cycle_R9", 0, {48'd0, rf[9]}, 64'd8);

        // Back-to-back with op_valid held; op2 reads op1's destination.
        run_op(4'd6, 4'd1, 4'd2, 1'b1, 1, 1'b0, 16'h0, 1'b1, 4'd7, 4'd6, 4'd6, 1'b1);
        run_op(4'd7, 4'd6, 4'd6, 1'b1, 0, 1'b0, 16'h0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0);
        chk("b2b_R7", 0, {48'd0, rf[7]}, 64'd16);

        // Reset for two cycles in the middle of EXEC: op dropped, no write-back.
        preload(4'd8, 16'hBEEF);
        alu_lat  = 1000;
        op_valid = 1'b1;
        op_rd    = 4'd8;
        op_rs1   = 4'd1;
        op_rs2   = 4'd2;
        op_wen   = 1'b1;
        @(posedge clk);
        #1 op_valid = 1'b0;
        repeat (5) @(negedge clk);
        res = 1'b1;
        repeat (2) @(negedge clk);
        res = 1'b0;
        chk("midexec_reset", 0,
            {29'd0, op_ready, LOUT, ROUT, lSel, rSel, OIN, oSel, o, alu_start, done, err},
            {29'd0, 35'h4_0000_0000});
        chk("midexec_operands", 0, {32'd0, alu_a, alu_b}, 64'd0);
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            chk("after_reset_quiet", i, {61'd0, OIN, done, op_ready}, 64'd1);
        end
        chk("after_reset_R8", 0, {48'd0, rf[8]}, 64'hBEEF);

        // Randomized ops, including timeouts and held op_valid.
        for (int i = 0; i < 21; i++) begin
            rops[i].rd   = 4'($urandom);
            rops[i].rs1  = 4'($urandom);
            rops[i].rs2  = 4'($urandom);
            rops[i].wen  = 1'($urandom);
            rops[i].lat  = int'($urandom_range(0, 18));
            rops[i].hold = 1'($urandom);
        end
        for (int i = 0; i < 20; i++) begin
            run_op(rops[i].rd, rops[i].rs1, rops[i].rs2, rops[i].wen, rops[i].lat, 1'b0, 16'h0,
                   rops[i].hold, rops[i+1].rd, rops[i+1].rs1, rops[i+1].rs2, rops[i+1].wen);
        end
        op_valid = 1'b0;

        for (int i = 0; i < 16; i++)
            chk("final_regfile", i, {48'd0, rf[i]}, {48'd0, refrf[i]});

        $display("== %0d vectors applied, %0d miscompares ==", nchk, nfail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
